ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset), over the shared key_clk/key_data lines.
- It is the opposite direction to the keyboard scan-code receiver, and the two sit side by side on the same pins.
- Both lines are open-drain: the block only pulls a line low or releases it. The board-level tristate lives outside this block.

Parameters:
- INHIBIT_CYCLES, 12000: clk_in cycles the clock is held low before the request (120 us at 100 MHz).
- START_TIMEOUT_CYCLES, 1500000: maximum wait from request to the first device falling edge (15 ms).
- XFER_TIMEOUT_CYCLES, 200000: maximum time from the first device falling edge to the ACK edge (2 ms).
- RETRY_MAX, 2: automatic retry attempts. Used only when PS2_TX_RETRY_EN is defined.

Ports:
- clk_in  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- tx_valid  input  1  request to send tx_data.
- tx_data  input  8  command byte.
- tx_ready  output  1  high only in IDLE.
- key_clk  input  1  PS/2 clock pin, sampled.
- key_data  input  1  PS/2 data pin, sampled.
- key_clk_oe  output  1  1 = pull the clock line low.
- key_data_oe  output  1  1 = pull the data line low.
- busy  output  1  high when not in IDLE. The receiver ignores the lines while busy=1.
- tx_done  output  1  one-cycle pulse when the transfer ends, successfully or not.
- tx_status  output  2  valid when tx_done=1: 00 ACK, 01 NACK, 10 start timeout, 11 transfer timeout.

Behaviour:
- Reset: asynchronous. All outputs go to 0 immediately except tx_ready, which is 1. Both lines are released. State goes to IDLE. A reset during a transfer aborts it without pulsing tx_done.
- Input sync: key_clk and key_data each pass through a 2-flop synchronizer with reset value 1. A falling edge is clk_r1 & ~clk_r0 (one cycle wide).
- Handshake: a byte is accepted on the cycle where tx_valid && tx_ready.
  - On accept, tx_data is latched and parity = ~^tx_data (odd parity).
  - tx_valid while busy is ignored; nothing is queued.
- States:
  - IDLE: both oe = 0. On accept go to INHIBIT.
  - INHIBIT: key_clk_oe = 1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: key_clk_oe = 1 and key_data_oe = 1 for REQ_SETUP_CYCLES (16) cycles. Then key_clk_oe = 0 and go to WAIT_CLK; key_data_oe stays 1 (start bit).
  - WAIT_CLK: the first falling edge goes to BITS and is handled as edge 1. More than START_TIMEOUT_CYCLES without an edge is a start timeout: release both lines and finish with status 10.
  - BITS: bit counter n increments on each falling edge. The host changes data only just after a falling edge, so data is stable for the device's rising-edge sample.
    - Edges 1 to 8: key_data_oe = ~tx_data[n-1] (LSB first).
    - Edge 9: key_data_oe = ~parity.
    - Edge 10: key_data_oe = 0 (stop bit, line released), then go to ACK.
  - ACK: on the next falling edge, sample synced data. 0 = ACK (status 00); 1 = NACK (status 01). Then go to WAIT_IDLE.
  - Transfer timeout: the XFER counter runs from edge 1 until the ACK edge. Overflow in BITS or ACK releases both lines and finishes with status 11 (no WAIT_IDLE).
  - WAIT_IDLE: wait until synced clock and synced data are both 1. Then pulse tx_done with tx_status for one cycle and return to IDLE, where tx_ready = 1 on the following cycle.
- Timeout counters: width $clog2 of the largest timeout parameter + 1. They saturate and never wrap.
- Edge corner cases:
  - A falling edge during INHIBIT or REQ is ignored, because our own clock pull causes it.
  - Extra falling edges after the ACK edge are ignored.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined:
  - On NACK or either timeout, re-enter INHIBIT with the latched byte, up to RETRY_MAX times.
  - tx_done pulses only on ACK or after the final failure, carrying the final status.
  - An extra output tx_retries[1:0] reports the attempts used.
- Undefined: a single attempt, no tx_retries port.

Decomposition:
- Package ps2_pkg holds:
  - state enum;
  - tx_status codes;
  - REQ_SETUP_CYCLES = 16;
  - FRAME_EDGES = 10.
- Sub-module ps2_line_sync: 2-flop synchronizer plus falling-edge detect for clock and data. The receiver reuses it.

Test Plan:
- Send 0xED to a device model that ACKs:
  - key_clk_oe is held for exactly 12000 cycles plus 16 REQ cycles;
  - the device samples 1,0,1,1,0,1,1,1 on edges 1 to 8, parity 1 on edge 9, and stop 1 on edge 10;
  - tx_done pulses once with tx_status = 00.
- Send 0x00: parity bit sampled = 1; 0xFF: parity bit = 1. Model holds data high on the ACK edge, so tx_status = 01.
- Model never clocks: after START_TIMEOUT_CYCLES both oe = 0, tx_status = 10, tx_ready returns to 1.
- Model stops after edge 5: tx_status = 11 after XFER_TIMEOUT_CYCLES from edge 1.
- tx_valid toggled while busy: no second transfer. Asserting rst at edge 4 clears both oe in the same cycle and produces no tx_done.
- With PS2_TX_RETRY_EN, the model NACKs twice then ACKs: three inhibit phases, one tx_done, tx_status = 00, tx_retries = 2.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared definitions for the PS/2 host transmitter and the
//               line synchronizer. These are the FSM state encoding, the
//               tx_status result codes, the frame timing constants and the
//               odd-parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Host transmitter FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_WAIT_CLK  = 3'd3,
        ST_BITS      = 3'd4,
        ST_ACK       = 3'd5,
        ST_WAIT_IDLE = 3'd6
    } ps2_state_e;

    // tx_status codes, valid while tx_done=1
    localparam logic [1:0] c_STATUS_ACK      = 2'b00;
    localparam logic [1:0] c_STATUS_NACK     = 2'b01;
    localparam logic [1:0] c_STATUS_START_TO = 2'b10;
    localparam logic [1:0] c_STATUS_XFER_TO  = 2'b11;

    // Clock and data are both held low for this many cycles to request to send
    localparam int REQ_SETUP_CYCLES = 16;
    // Device falling edges: 8 data bits, then parity, then stop
    localparam int FRAME_EDGES      = 10;

    // Odd parity: the data bits plus the parity bit hold an odd number of ones
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : ps2_line_sync
// Description : Two-flop synchronizer for the PS/2 clock and data pins, plus
//               a one-cycle falling-edge strobe on the synchronized clock.
//               The scan-code receiver instantiates this block as well.
// Ports       : clk_in    - system clock
//               rst       - asynchronous reset, active-high (flops go to 1)
//               key_clk   - raw PS/2 clock pin
//               key_data  - raw PS/2 data pin
//               clk_sync  - synchronized clock level
//               data_sync - synchronized data level
//               clk_fall  - one-cycle pulse on a synchronized clock 1->0
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_sync (
    input  logic clk_in,
    input  logic rst,
    input  logic key_clk,
    input  logic key_data,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    // [0] is the metastability stage and [1] is the synchronized value
    logic [1:0] r_clk_sync;
    logic [1:0] r_data_sync;
    logic       r_clk_prev;

    // Reset to 1 so that releasing reset on an idle bus gives no false edge
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], key_clk};
            r_data_sync <= {r_data_sync[0], key_data};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    assign clk_sync  = r_clk_sync[1];
    assign data_sync = r_data_sync[1];
    assign clk_fall  = r_clk_prev & ~r_clk_sync[1];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device command transmitter (open-drain). The
//               sequence is: inhibit the clock, request to send, shift out the
//               LSB-first byte with odd parity and a stop bit on the device's
//               falling edges, then sample the device ACK.
// Ports       : clk_in, rst           - clock, asynchronous active-high reset
//               tx_valid/tx_data      - command byte request
//               tx_ready              - high only in IDLE
//               key_clk/key_data      - sampled PS/2 pins
//               key_clk_oe/key_data_oe- 1 = pull the line low
//               busy                  - high outside IDLE
//               tx_done/tx_status     - end-of-transfer pulse and result code
//               tx_retries            - attempts used (PS2_TX_RETRY_EN only)
// Config      : define PS2_TX_RETRY_EN to retry NACKs and timeouts up to
//               RETRY_MAX times. This also adds the RETRY_MAX parameter and
//               the tx_retries output.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES       = 12000,
    parameter int START_TIMEOUT_CYCLES = 1500000,
    parameter int XFER_TIMEOUT_CYCLES  = 200000
`ifdef PS2_TX_RETRY_EN
    ,
    parameter int RETRY_MAX            = 2
`endif
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       key_clk,
    input  logic       key_data,
    output logic       key_clk_oe,
    output logic       key_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic [1:0] tx_status
`ifdef PS2_TX_RETRY_EN
    ,
    output logic [1:0] tx_retries
`endif
);

    localparam int c_CNT_MAX_A = (START_TIMEOUT_CYCLES > XFER_TIMEOUT_CYCLES) ?
                                 START_TIMEOUT_CYCLES : XFER_TIMEOUT_CYCLES;
    localparam int c_CNT_MAX   = (c_CNT_MAX_A > INHIBIT_CYCLES) ? c_CNT_MAX_A : INHIBIT_CYCLES;
    localparam int c_CNT_W     = $clog2(c_CNT_MAX) + 1;

    localparam logic [c_CNT_W-1:0] c_INHIBIT_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_REQ_LAST     = c_CNT_W'(REQ_SETUP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_START_LAST   = c_CNT_W'(START_TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_XFER_LAST    = c_CNT_W'(XFER_TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);

    ps2_state_e         r_state;
    logic [7:0]         r_byte;
    logic               r_parity;
    logic [c_CNT_W-1:0] r_cnt;       // inhibit, request and start-timeout phases
    logic [c_CNT_W-1:0] r_xfer;      // edge 1 through the ACK edge
    logic [3:0]         r_edge;      // device falling edges seen so far
    logic               r_clk_oe;
    logic               r_data_oe;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic [1:0]         r_status;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]         r_retries;
`endif

    logic       w_clk_sync;
    logic       w_data_sync;
    logic       w_clk_fall;
    logic       w_end;
    logic [1:0] w_end_status;

    ps2_line_sync u_sync (
        .clk_in    (clk_in),
        .rst       (rst),
        .key_clk   (key_clk),
        .key_data  (key_data),
        .clk_sync  (w_clk_sync),
        .data_sync (w_data_sync),
        .clk_fall  (w_clk_fall)
    );

    // The current attempt ends this cycle (a timeout, or the bus going idle after ACK)
    always_comb begin
        w_end        = 1'b0;
        w_end_status = c_STATUS_ACK;
        case (r_state)
            ST_WAIT_CLK: begin
                if (!w_clk_fall && r_cnt >= c_START_LAST) begin
                    w_end        = 1'b1;
                    w_end_status = c_STATUS_START_TO;
                end
            end
            ST_BITS, ST_ACK: begin
                if (r_xfer >= c_XFER_LAST) begin
                    w_end        = 1'b1;
                    w_end_status = c_STATUS_XFER_TO;
                end
            end
            ST_WAIT_IDLE: begin
                if (w_clk_sync && w_data_sync) begin
                    w_end        = 1'b1;
                    w_end_status = r_status;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_byte    <= 8'h00;
            r_parity  <= 1'b0;
            r_cnt     <= '0;
            r_xfer    <= '0;
            r_edge    <= 4'd0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_status  <= c_STATUS_ACK;
`ifdef PS2_TX_RETRY_EN
            r_retries <= 2'd0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_end) begin
`ifdef PS2_TX_RETRY_EN
                if (w_end_status != c_STATUS_ACK && r_retries < 2'(RETRY_MAX)) begin
                    // Start over from the clock inhibit with the byte still latched
                    r_retries <= r_retries + 2'd1;
                    r_state   <= ST_INHIBIT;
                    r_clk_oe  <= 1'b1;
                    r_data_oe <= 1'b0;
                    r_cnt     <= '0;
                end else
`endif
                begin
                    r_state   <= ST_IDLE;
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_done    <= 1'b1;
                    r_status  <= w_end_status;
                    r_ready   <= 1'b1;
                    r_busy    <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (tx_valid && r_ready) begin
                            r_byte    <= tx_data;
                            r_parity  <= odd_parity(tx_data);
                            r_state   <= ST_INHIBIT;
                            r_clk_oe  <= 1'b1;
                            r_cnt     <= '0;
                            r_ready   <= 1'b0;
                            r_busy    <= 1'b1;
`ifdef PS2_TX_RETRY_EN
                            r_retries <= 2'd0;
`endif
                        end
                    end
                    // Falling edges seen here come from our own clock pull and are ignored
                    ST_INHIBIT: begin
                        if (r_cnt == c_INHIBIT_LAST) begin
                            r_state   <= ST_REQ;
                            r_data_oe <= 1'b1;
                            r_cnt     <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    ST_REQ: begin
                        if (r_cnt == c_REQ_LAST) begin
                            // Release the clock; data stays low as the start bit
                            r_state  <= ST_WAIT_CLK;
                            r_clk_oe <= 1'b0;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    ST_WAIT_CLK: begin
                        if (w_clk_fall) begin
                            // This is edge 1, so drive data bit 0 straight away
                            r_state   <= ST_BITS;
                            r_edge    <= 4'd1;
                            r_data_oe <= ~r_byte[0];
                            r_xfer    <= '0;
                        end else if (r_cnt != '1) begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    ST_BITS: begin
                        if (r_xfer != '1) begin
                            r_xfer <= r_xfer + c_CNT_ONE;
                        end
                        if (w_clk_fall) begin
                            r_edge <= r_edge + 4'd1;
                            if (r_edge <= 4'd7) begin
                                r_data_oe <= ~r_byte[r_edge[2:0]];
                            end else if (r_edge == 4'(FRAME_EDGES - 2)) begin
                                r_data_oe <= ~r_parity;
                            end else begin
                                r_data_oe <= 1'b0;
                                r_state   <= ST_ACK;
                            end
                        end
                    end
                    ST_ACK: begin
                        if (r_xfer != '1) begin
                            r_xfer <= r_xfer + c_CNT_ONE;
                        end
                        if (w_clk_fall) begin
                            r_status <= w_data_sync ? c_STATUS_NACK : c_STATUS_ACK;
                            r_state  <= ST_WAIT_IDLE;
                        end
                    end
                    // Further device edges are ignored until the bus goes idle
                    ST_WAIT_IDLE: ;
                    default: begin
                        r_state   <= ST_IDLE;
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_ready   <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_ready    = r_ready;
    assign busy        = r_busy;
    assign key_clk_oe  = r_clk_oe;
    assign key_data_oe = r_data_oe;
    assign tx_done     = r_done;
    assign tx_status   = r_status;
`ifdef PS2_TX_RETRY_EN
    assign tx_retries  = r_retries;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Testbench for ps2_host_tx. It uses an open-drain PS/2 device
//               model that clocks frames and then ACKs, NACKs, never clocks,
//               stalls or triggers a reset. Expected results are pushed to a
//               scoreboard when each byte is issued, and a monitor pops and
//               compares them on every tx_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH       = 200;
    localparam int START_TO  = 3000;
    localparam int XFER_TO   = 2000;
    localparam int RETRY_MAX = 2;
    localparam int REQ_CYC   = 16;
    localparam int H         = 20;     // device half clock period, in clk_in cycles
`ifdef PS2_TX_RETRY_EN
    localparam bit RETRY_EN  = 1'b1;
`else
    localparam bit RETRY_EN  = 1'b0;
`endif
    localparam int M_ACK = 0, M_NACK = 1, M_NOCLK = 2, M_STALL = 3, M_RST = 4;

    typedef struct { int mode; logic [7:0] b; } dev_item_t;
    typedef struct { logic [1:0] status; logic [1:0] retries; } exp_t;

    logic       clk_in   = 1'b0;
    logic       rst      = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_ready, key_clk_oe, key_data_oe, busy, tx_done;
    logic [1:0] tx_status;
`ifdef PS2_TX_RETRY_EN
    logic [1:0] tx_retries;
`endif
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       key_clk, key_data;

    // Wired-AND of the open-drain bus
    assign key_clk  = dev_clk  & ~key_clk_oe;
    assign key_data = dev_data & ~key_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES       (INH),
        .START_TIMEOUT_CYCLES (START_TO),
        .XFER_TIMEOUT_CYCLES  (XFER_TO)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .key_clk     (key_clk),
        .key_data    (key_data),
        .key_clk_oe  (key_clk_oe),
        .key_data_oe (key_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_status   (tx_status)
`ifdef PS2_TX_RETRY_EN
        ,
        .tx_retries  (tx_retries)
`endif
    );

    always #5 clk_in = ~clk_in;

    int        checks = 0;
    int        errors = 0;
    int        cyc = 0;
    int        n_done = 0;
    int        n_inhibit = 0;
    int        t_done = 0;
    int        t_edge1 = 0;
    int        dev_edges = 0;
    int        inh_run = 0;
    int        inh_both = 0;
    dev_item_t dev_q[$];
    exp_t      sb[$];
    exp_t      mon_e;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] status_of(input int mode);
        case (mode)
            M_ACK:   return 2'b00;
            M_NACK:  return 2'b01;
            M_NOCLK: return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    // Scoreboard monitor
    always @(negedge clk_in) begin
        if (!rst && tx_done) begin
            n_done++;
            t_done = cyc;
            chk("done_expected", longint'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("tx_status", tx_status, mon_e.status);
`ifdef PS2_TX_RETRY_EN
                chk("tx_retries", tx_retries, mon_e.retries);
`endif
            end
        end
    end

    // Length of each clock-inhibit phase, and of the request part within it
    always @(negedge clk_in) begin
        if (rst) begin
            inh_run  = 0;
            inh_both = 0;
        end else if (key_clk_oe) begin
            inh_run++;
            if (key_data_oe) inh_both++;
        end else if (inh_run != 0) begin
            chk("clk_inhibit_len", inh_run, INH + REQ_CYC);
            chk("req_setup_len", inh_both, REQ_CYC);
            n_inhibit++;
            inh_run  = 0;
            inh_both = 0;
        end
    end

    // PS/2 device model
    initial begin
        dev_item_t  d;
        logic [9:0] got;
        logic [9:0] expv;
        int         ones;
        forever begin
            do @(negedge clk_in); while (key_clk !== 1'b0);
            do @(negedge clk_in); while (!(key_clk === 1'b1 && key_data === 1'b0));
            dev_edges = 0;
            chk("dev_request_expected", longint'(dev_q.size() > 0), 1);
            if (dev_q.size() == 0) continue;
            d = dev_q.pop_front();
            if (d.mode == M_NOCLK) continue;
            repeat (10) @(negedge clk_in);
            got = '0;
            for (int i = 1; i <= 10; i++) begin
                if (d.mode == M_STALL && i == 6) break;
                dev_clk   = 1'b0;
                dev_edges = i;
                if (i == 1) t_edge1 = cyc;
                if (d.mode == M_RST && i == 4) begin
                    wait (rst === 1'b1);
                    dev_clk = 1'b1;
                    break;
                end
                repeat (H) @(negedge clk_in);
                dev_clk    = 1'b1;
                got[i-1]   = key_data;
                repeat (H) @(negedge clk_in);
            end
            if (d.mode == M_ACK || d.mode == M_NACK) begin
                ones = 0;
                for (int k = 0; k < 8; k++) begin
                    expv[k] = d.b[k];
                    ones += int'(d.b[k]);
                end
                expv[8] = (ones % 2 == 0);
                expv[9] = 1'b1;
                chk("frame_bits", got, expv);
                if (d.mode == M_ACK) dev_data = 1'b0;
                repeat (2) @(negedge clk_in);
                dev_clk = 1'b0;
                repeat (H) @(negedge clk_in);
                dev_clk = 1'b1;
                repeat (2) @(negedge clk_in);
                dev_data = 1'b1;
            end
        end
    end

    task automatic handshake(input logic [7:0] b, input bit toggle);
        int t = 0;
        while (!tx_ready && t < 1000) begin @(negedge clk_in); t++; end
        @(negedge clk_in);
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk_in);
        tx_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        if (toggle) begin
            repeat (300) begin
                @(negedge clk_in);
                tx_valid = 1'($urandom_range(0, 1));
                tx_data  = 8'($urandom);
            end
            tx_valid = 1'b0;
        end
    endtask

    // Reference model: the device attempts that will be used and the final result
    task automatic send(input logic [7:0] b, input int m0, input int m1, input int m2, input bit toggle);
        int         modes[3];
        int         tries, used, done0, inh0, t;
        logic [1:0] st;
        dev_item_t  d;
        exp_t       e;
        modes[0] = m0; modes[1] = m1; modes[2] = m2;
        tries = RETRY_EN ? RETRY_MAX + 1 : 1;
        used  = 0;
        st    = 2'b00;
        for (int i = 0; i < tries; i++) begin
            d.mode = modes[i];
            d.b    = b;
            dev_q.push_back(d);
            used++;
            st = status_of(modes[i]);
            if (modes[i] == M_ACK) break;
        end
        e.status  = st;
        e.retries = 2'(used - 1);
        sb.push_back(e);
        done0 = n_done;
        inh0  = n_inhibit;
        handshake(b, toggle);
        t = 0;
        while (n_done == done0 && t < 40000) begin @(negedge clk_in); t++; end
        chk("done_count", n_done - done0, 1);
        repeat (2) @(negedge clk_in);
        chk("ready_after_done", tx_ready, 1);
        chk("clk_oe_after_done", key_clk_oe, 0);
        chk("data_oe_after_done", key_data_oe, 0);
        chk("inhibit_phases", n_inhibit - inh0, used);
        if (toggle) begin
            repeat (30) @(negedge clk_in);
            chk("no_second_xfer_busy", busy, 0);
            chk("no_second_xfer_clk_oe", key_clk_oe, 0);
        end
    endtask

    initial begin
        int         t, delta, done0;
        dev_item_t  d;
        logic [7:0] b;
        repeat (5) @(negedge clk_in);
        chk("reset_tx_ready", tx_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_clk_oe", key_clk_oe, 0);
        chk("reset_data_oe", key_data_oe, 0);
        chk("reset_tx_done", tx_done, 0);
        chk("reset_tx_status", tx_status, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk_in);

        send(8'hED, M_ACK, M_ACK, M_ACK, 1'b0);
        send(8'h00, M_NACK, M_NACK, M_NACK, 1'b0);
        send(8'hFF, M_NACK, M_NACK, M_NACK, 1'b0);
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            send(b, $urandom_range(0, 1), $urandom_range(0, 1), M_ACK, 1'b0);
        end
        send(8'h81, M_NOCLK, M_NOCLK, M_NOCLK, 1'b0);
        send(8'h3C, M_STALL, M_STALL, M_STALL, 1'b0);
        delta = t_done - t_edge1;
        checks++;
        if (delta < XFER_TO || delta > XFER_TO + 8) begin
            errors++;
            $display("FAIL xfer_timeout_latency: got %0d cycles expected %0d..%0d", delta, XFER_TO, XFER_TO + 8);
        end
        send(8'hA5, M_ACK, M_ACK, M_ACK, 1'b1);

        // Reset in the middle of the frame, at device edge 4
        d.mode = M_RST;
        d.b    = 8'h5A;
        dev_q.push_back(d);
        done0 = n_done;
        handshake(8'h5A, 1'b0);
        t = 0;
        while (dev_edges != 4 && t < 5000) begin @(negedge clk_in); t++; end
        chk("rst_reached_edge4", dev_edges, 4);
        @(posedge clk_in);
        #2 rst = 1'b1;
        #1;
        chk("rst_clk_oe", key_clk_oe, 0);
        chk("rst_data_oe", key_data_oe, 0);
        chk("rst_tx_done", tx_done, 0);
        chk("rst_tx_ready", tx_ready, 1);
        repeat (4) @(negedge clk_in);
        rst = 1'b0;
        repeat (100) @(negedge clk_in);
        chk("rst_no_done", n_done - done0, 0);
        chk("rst_idle_ready", tx_ready, 1);

`ifdef PS2_TX_RETRY_EN
        send(8'hED, M_NACK, M_NACK, M_ACK, 1'b0);
`endif
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
